// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle with a registered carry between chunks.
// Latency: done NCHUNK cycles after start is accepted; start is ignored while busy (no queueing).
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] s_k;
  logic             c_out;
  logic             c_msb;
  logic             last;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign accept = start && (state != RUN);
  assign last   = (cnt_q == CW'(NCHUNK - 1));

  // One chunk slice of the operands, selected by the chunk counter.
  always_comb begin
    a_k = CHUNK'(a_q >> (cnt_q * CHUNK));
    b_k = CHUNK'(b_q >> (cnt_q * CHUNK));
    {c_out, s_k} = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the MSB sum bit.
    c_msb   = s_k[CHUNK-1] ^ a_k[CHUNK-1] ^ b_k[CHUNK-1];
    res_nxt = res_q | (WIDTH'(s_k) << (cnt_q * CHUNK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_nxt;
      carry_q <= c_out;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      // Results appear only on the final chunk so no partial sum is ever visible.
      if (last) begin
        sum_q  <= res_nxt;
        cout_q <= c_out;
        ovf_q  <= c_out ^ c_msb;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed and random checks of chunked_seq_adder at CHUNK=4 and CHUNK=16.
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        start4 = 1'b0;
  logic        start16 = 1'b0;
  logic        busy4, done4, cout4, ovf4;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum4, sum16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    return (w == 16) ? done16 : done4;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 16) ? busy16 : busy4;
  endfunction

  function automatic logic [17:0] res_of(input int w);
    return (w == 16) ? {ovf16, cout16, sum16} : {ovf4, cout4, sum4};
  endfunction

  // Reference: {ovf, cout, sum} from plain 17-bit arithmetic and sign rules.
  function automatic logic [17:0] model(input logic [15:0] aa, input logic [15:0] bb,
                                        input logic ci, input logic sb);
    logic [16:0] t;
    logic        co;
    logic        ov;
    if (sb) begin
      t  = {1'b0, aa} - {1'b0, bb} - {16'd0, ci};
      co = ~t[16];
      ov = (aa[15] != bb[15]) && (t[15] != aa[15]);
    end else begin
      t  = {1'b0, aa} + {1'b0, bb} + {16'd0, ci};
      co = t[16];
      ov = (aa[15] == bb[15]) && (t[15] != aa[15]);
    end
    return {ov, co, t[15:0]};
  endfunction

  // Issues one operation and waits for done; ends on the negedge where done is high.
  task automatic do_op(input int w, input logic [15:0] aa, input logic [15:0] bb,
                       input logic ci, input logic sb,
                       output int lat, output int nbusy, output bit held);
    logic [17:0] r0;
    @(negedge clk);
    a = aa; b = bb; cin = ci; sub = sb;
    if (w == 16) start16 = 1'b1; else start4 = 1'b1;
    r0 = res_of(w);
    @(negedge clk);
    start4 = 1'b0; start16 = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0; nbusy = 0; held = 1'b1;
    while (!done_of(w) && lat < 40) begin
      if (busy_of(w)) nbusy++;
      if (res_of(w) !== r0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_chk(input string tag, input int w, input logic [15:0] aa,
                         input logic [15:0] bb, input logic ci, input logic sb,
                         input logic [17:0] exp, input bit pulse_chk);
    int lat, nbusy;
    bit held;
    int nch;
    nch = (w == 16) ? 1 : 4;
    do_op(w, aa, bb, ci, sb, lat, nbusy, held);
    chk({tag, "_lat"}, lat, nch);
    chk({tag, "_busycyc"}, nbusy, nch);
    chk({tag, "_hold"}, 32'(held), 1);
    chk({tag, "_busy_at_done"}, 32'(busy_of(w)), 0);
    chk({tag, "_sum"}, 32'(res_of(w) & 18'hFFFF), 32'(exp[15:0]));
    chk({tag, "_cout"}, 32'(res_of(w) >> 16 & 18'h1), 32'(exp[16]));
    chk({tag, "_ovf"}, 32'(res_of(w) >> 17), 32'(exp[17]));
    if (pulse_chk) begin
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done_of(w)), 0);
    end
  endtask

  initial begin
    int lat, extra;
    logic [15:0] ra, rb;
    logic rc, rs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_sum4", 32'(sum4), 0);
    chk("rst_cout4", 32'(cout4), 0);
    chk("rst_ovf4", 32'(ovf4), 0);
    chk("rst_busy16", 32'(busy16), 0);
    chk("rst_done16", 32'(done16), 0);
    chk("rst_sum16", 32'(sum16), 0);
    chk("rst_cout16", 32'(cout16), 0);
    chk("rst_ovf16", 32'(ovf16), 0);
    rst_n = 1'b1;

    // Directed vectors, expected {ovf, cout, sum} hand-computed
    run_chk("add_basic", 4, 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b1);
    run_chk("add_ripple", 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}, 1'b1);
    run_chk("add_ovf", 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 1'b1);
    run_chk("sub_neg", 4, 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
    run_chk("sub_ovf", 4, 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1'b1);
    run_chk("sub_bin", 4, 16'h0010, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 16'h000E}, 1'b1);
    run_chk("add_cin", 4, 16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100}, 1'b1);
    run_chk("w16_add", 16, 16'hABCD, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'hBCDE}, 1'b1);
    run_chk("w16_sub", 16, 16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF}, 1'b1);

    // start re-pulsed during RUN is ignored
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    a = 16'h1000; b = 16'h1000; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 2;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("repulse_lat", lat, 4);
    chk("repulse_sum", 32'(sum4), 32'h0007);

    // Back-to-back start in the DONE cycle
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("b2b_done_drop", 32'(done4), 0);
    chk("b2b_busy_rise", 32'(busy4), 1);
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", lat, 4);
    chk("b2b_sum", 32'(sum4), 32'h0002);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) extra++;
    end
    chk("no_extra_done", extra, 0);

    // Reset during chunk 2 aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_done", 32'(done4), 0);
    chk("abort_sum", 32'(sum4), 0);
    chk("abort_cout", 32'(cout4), 0);
    chk("abort_ovf", 32'(ovf4), 0);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) extra++;
    end
    chk("abort_no_done", extra, 0);

    // Random vectors against the reference model, both chunk sizes
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_chk("rnd4", 4, ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_chk("rnd16", 16, ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
